// File: rtl/sram_arbiter.sv
// Two-port arbiter sharing a single SRAM controller between the MEM-stage port (0) and a secondary port (1).
// Ties go to port 0 by default; define ARB_ROUND_ROBIN_EN to alternate the preferred port after every access.
module sram_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_rd_en,
  input  logic              p0_wr_en,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_ready,
  input  logic              p1_rd_en,
  input  logic              p1_wr_en,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_ready,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic req0, req1, pick1;

  assign req0 = p0_rd_en | p0_wr_en;
  assign req1 = p1_rd_en | p1_wr_en;

`ifdef ARB_ROUND_ROBIN_EN
  logic prio_q, prio_d;

  // On a tie the port named by the pointer wins.
  assign pick1 = req1 & (~req0 | prio_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prio_q <= 1'b0;
    else     prio_q <= prio_d;
  end
`else
  assign pick1 = req1 & ~req0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    prio_d   = prio_q;
`endif

    unique case (state_q)
      IDLE: begin
        rd_d = 1'b0;
        wr_d = 1'b0;
        if (req0 | req1) begin
          grant_d = pick1;
          // A write wins over a simultaneous read from the same port.
          wr_d    = pick1 ? p1_wr_en : p0_wr_en;
          rd_d    = pick1 ? (p1_rd_en & ~p1_wr_en) : (p0_rd_en & ~p0_wr_en);
          addr_d  = pick1 ? p1_addr : p0_addr;
          wdata_d = pick1 ? p1_wdata : p0_wdata;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // The controller's ready can glitch high before it loads, so the first BUSY cycle is ignored.
        if ((cnt_q != '0) && mem_ready) begin
          if (rd_q) begin
            if (grant_q) rdata1_d = mem_rdata;
            else         rdata0_d = mem_rdata;
          end
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
        prio_d  = ~grant_q;
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  assign mem_rd_en = rd_q;
  assign mem_wr_en = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;
  assign err       = err_q;

  assign p0_ready = ~req0 | ((state_q == DONE) & ~grant_q);
  assign p1_ready = ~req1 | ((state_q == DONE) &  grant_q);

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-port arbiter that shares the single SRAM controller between the MEM-stage data port (port 0) and a secondary requester (port 1, instruction fetch or DMA).
- Accepts level-held read/write requests from each port and grants one at a time.
- Drives the controller's wr_en/rd_en/address/writeData, waits for its ready, returns read data and a per-port ready that stalls the requester until its access completes.

Parameters:
- ADDR_W, 32, request/controller address width
- DATA_W, 32, data width
- TIMEOUT, 15, max BUSY cycles before abort; counter width = clog2(TIMEOUT+1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- p0_rd_en  in  1  port 0 read request (held until p0_ready)
- p0_wr_en  in  1  port 0 write request (held until p0_ready)
- p0_addr  in  ADDR_W  port 0 byte address
- p0_wdata  in  DATA_W  port 0 write data
- p0_rdata  out  DATA_W  port 0 read data, registered
- p0_ready  out  1  port 0 not-stalled
- p1_rd_en, p1_wr_en, p1_addr, p1_wdata, p1_rdata, p1_ready  same as port 0, for port 1
- mem_rd_en  out  1  to controller rd_en
- mem_wr_en  out  1  to controller wr_en
- mem_addr  out  ADDR_W  to controller address
- mem_wdata  out  DATA_W  to controller writeData
- mem_rdata  in  DATA_W  from controller readData
- mem_ready  in  1  from controller ready; high when idle or access complete
- err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset: state IDLE; mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, p0_rdata=p1_rdata=0, err=0, grant=0, priority pointer=0. Reset mid-access aborts immediately; no completion pulse is produced.
- A port requests when rd_en|wr_en. If both are set, the access is a write; rd_en is ignored.
- pX_ready = ~(pX_rd_en|pX_wr_en) | doneX. doneX is high only in DONE with grant==X. This output is combinational from inputs and state.
- FSM IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - Enables low.
  - If any request is pending, latch grant, the request type, and the granted port's addr/wdata into the mem_* registers.
  - Set the matching mem_rd_en or mem_wr_en, clear the timeout counter, go BUSY.
- BUSY:
  - Hold mem_* registers stable; requester inputs are ignored.
  - The counter increments each cycle.
  - If mem_ready=1, capture mem_rdata into the granted port's rdata (reads only; writes leave rdata unchanged), drop enables, go DONE.
  - Else if counter==TIMEOUT, drop enables, pulse err, go DONE; rdata is unchanged.
  - mem_ready is sampled only from the second BUSY cycle onward, because the controller's ready is combinational and may be high in the first cycle before its counter loads.
- DONE:
  - Enables low for exactly one cycle, which lets the controller's counter reload.
  - The granted port's ready=1, so the requester advances.
  - Go IDLE and update the priority pointer.
- Latency: request at edge N is issued at N+1. Minimum 4 cycles from request to ready, plus the controller access time. There is at least one idle-enable cycle between back-to-back accesses.
- Simultaneous requests: resolved by the priority rule below. The losing port keeps ready=0 and is served on the next IDLE.
- Request dropped by the requester while BUSY: the access still completes; the result is discarded and no ready is generated.
- mem_addr and mem_wdata hold their last values in IDLE and DONE.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: round-robin. The pointer names the preferred port. After each completion (including timeout), the pointer becomes ~grant. On a tie, the pointer's port wins.
- Undefined: fixed priority; port 0 always wins ties. The pointer register is absent.

Test Plan:
- Reset asserted during BUSY with p0 read at 0x400 -> next edge: IDLE, mem_rd_en=0, p0_rdata=0, err=0; request re-issued after reset release.
- p0 read 0x404, controller model returns 0xDEADBEEF after 3 cycles -> p0_rdata=0xDEADBEEF, p0_ready high exactly one cycle in DONE, p1_rdata unchanged.
- p0 write 0x408 data 0x12345678 with p0_rd_en also high -> mem_wr_en=1, mem_rd_en=0 while BUSY, mem_wdata=0x12345678.
- p0 and p1 read together, held for 3 accesses:
  - Fixed priority: grants p0, p0, p0 while p1 stays stalled.
  - ARB_ROUND_ROBIN_EN: grants p0, p1, p0.
- Controller model holds mem_ready=0 -> after TIMEOUT=15 BUSY cycles, err pulses one cycle, the granted port's ready=1, and rdata is unchanged.
- p1 drops its request mid-BUSY -> access completes, p1_ready never pulses from doneX, FSM returns to IDLE, and a pending p0 request is then served.
